load_store_unit: RTL and testbench

- Initiator side of the data-memory interface: sits between the core's execute stage and the word-wide data memory.
- The memory has a combinational read, a single word write-enable and no byte enables.
- This block issues word reads and writes and extracts/sign-extends sub-word loads.
- Sub-word stores (SB/SH) are done as read-modify-write sequences.

---
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: word-wide data-memory initiator with sub-word extract and read-modify-write stores.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing alignment.
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ,
   input  logic              WR,
   input  logic [2:0]        FUNCT3,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] WDATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic [DATA_W-1:0] RDATA,
   output logic [ADDR_W-1:0] MEM_A,
   output logic [DATA_W-1:0] MEM_WD,
   output logic              MEM_WE,
   input  logic [DATA_W-1:0] MEM_RD
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   state_t            state, state_nxt;
   logic              wr_q, err_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q, addr_in;
   logic [DATA_W-1:0] wdata_q, merge_q;
   logic              illegal, req_err, word_store;

   function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                      input logic [2:0] f3, input logic [1:0] lo);
      logic [DATA_W-1:0] sh;
      logic [7:0]        b;
      logic [15:0]       h;
      sh = word >> {lo, 3'b000};
      b  = sh[7:0];
      h  = lo[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  load_extract = {{24{b[7]}}, b};
         3'b100:  load_extract = {24'h0, b};
         3'b001:  load_extract = {{16{h[15]}}, h};
         3'b101:  load_extract = {16'h0, h};
         default: load_extract = word;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] merge_store(input logic [DATA_W-1:0] word,
                                                     input logic [DATA_W-1:0] wd,
                                                     input logic [2:0] f3, input logic [1:0] lo);
      logic [DATA_W-1:0] res;
      res = word;
      if (f3[0]) res[{lo[1], 4'b0000} +: 16] = wd[15:0];
      else       res[{lo, 3'b000} +: 8]      = wd[7:0];
      merge_store = res;
   endfunction

   assign illegal = (FUNCT3 == 3'b011) || (FUNCT3[2:1] == 2'b11) || (FUNCT3[2] && WR);

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign;
   assign misalign = (FUNCT3[1:0] == 2'b01 && ADDR[0]) || (FUNCT3 == 3'b010 && ADDR[1:0] != 2'b00);
   assign req_err  = illegal || misalign;
   assign addr_in  = ADDR;
`else
   // Without the trap, drop the low address bits the access width cannot use.
   assign req_err = illegal;
   always_comb begin
      addr_in = ADDR;
      if (FUNCT3[1:0] == 2'b01) addr_in[0]   = 1'b0;
      if (FUNCT3[1:0] == 2'b10) addr_in[1:0] = 2'b00;
   end
`endif

   assign word_store = wr_q && (f3_q == 3'b010);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         err_q <= 1'b0;
         RDATA <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && REQ) err_q <= req_err;
         if (state == ACCESS && !wr_q) RDATA <= load_extract(MEM_RD, f3_q, addr_q[1:0]);
      end
   end

   always_ff @(posedge CLK) begin
      if (state == IDLE && REQ) begin
         wr_q    <= WR;
         f3_q    <= FUNCT3;
         addr_q  <= addr_in;
         wdata_q <= WDATA;
      end
      if (state == ACCESS) merge_q <= merge_store(MEM_RD, wdata_q, f3_q, addr_q[1:0]);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (REQ) state_nxt = req_err ? RESP : ACCESS;
         ACCESS:  state_nxt = (!wr_q || word_store) ? RESP : WRITE;
         WRITE:   state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   // RST gates the strobes so an abort never writes or completes on the reset edge.
   always_comb begin
      BUSY   = (state != IDLE);
      DONE   = (state == RESP) && !RST;
      ERR    = (state == RESP) && !RST && err_q;
      MEM_A  = '0;
      MEM_WD = '0;
      MEM_WE = 1'b0;
      case (state)
         ACCESS: begin
            MEM_A = {addr_q[ADDR_W-1:2], 2'b00};
            if (word_store) begin
               MEM_WE = !RST;
               MEM_WD = wdata_q;
            end
         end
         WRITE: begin
            MEM_A  = {addr_q[ADDR_W-1:2], 2'b00};
            MEM_WE = !RST;
            MEM_WD = merge_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small word memory model.
module tb_load_store_unit;
   logic        CLK = 1'b0;
   logic        RST, REQ, WR;
   logic [2:0]  FUNCT3;
   logic [31:0] ADDR, WDATA;
   logic        BUSY, DONE, ERR, MEM_WE;
   logic [31:0] RDATA, MEM_A, MEM_WD, MEM_RD;

   logic [31:0] mem [0:63];
   logic        load_en = 1'b0;
   logic [5:0]  load_idx;
   logic [31:0] load_val;

   int errors = 0;
   int checks = 0;
   int done_cyc, we_cnt, we_cyc, a_cnt;
   logic err_seen;

   load_store_unit dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .WR(WR), .FUNCT3(FUNCT3), .ADDR(ADDR), .WDATA(WDATA),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .MEM_A(MEM_A), .MEM_WD(MEM_WD),
      .MEM_WE(MEM_WE), .MEM_RD(MEM_RD)
   );

   always #5 CLK = ~CLK;

   assign MEM_RD = mem[MEM_A[7:2]];
   always @(posedge CLK) begin
      if (MEM_WE) mem[MEM_A[7:2]] <= MEM_WD;
      else if (load_en) mem[load_idx] <= load_val;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic preload(input logic [31:0] byte_addr, input logic [31:0] val);
      load_idx = byte_addr[7:2];
      load_val = val;
      load_en  = 1'b1;
      tick();
      load_en  = 1'b0;
   endtask

   // One request; records completion cycle, write strobes and bus activity, then returns to IDLE.
   task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      WR = wr; FUNCT3 = f3; ADDR = a; WDATA = wd; REQ = 1'b1;
      tick();
      REQ = 1'b0;
      done_cyc = -1; we_cnt = 0; we_cyc = -1; a_cnt = 0; err_seen = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         if (MEM_WE) begin we_cnt++; we_cyc = n; end
         if (MEM_A != 32'h0) a_cnt++;
         if (DONE) begin done_cyc = n; err_seen = ERR; break; end
         tick();
      end
      tick();
   endtask

   task automatic test_reset;
      RST = 1'b1; REQ = 1'b0; WR = 1'b0; FUNCT3 = 3'b010; ADDR = 32'h0; WDATA = 32'h0;
      tick(); tick();
      RST = 1'b0;
      checks++;
      if ({BUSY, DONE, ERR, MEM_WE} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {BUSY, DONE, ERR, MEM_WE}); end
      checks++;
      if (RDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", RDATA); end
      checks++;
      if ({MEM_A, MEM_WD} !== 64'h0) begin errors++; $display("FAIL reset_bus: got %h/%h want 0/0", MEM_A, MEM_WD); end
   endtask

   task automatic test_load_word;
      preload(32'h40, 32'h8899AABB);
      run_req(1'b0, 3'b010, 32'h40, 32'h0);
      checks++;
      if (done_cyc !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", done_cyc); end
      checks++;
      if (RDATA !== 32'h8899AABB) begin errors++; $display("FAIL lw_rdata: got %h want 8899aabb", RDATA); end
      checks++;
      if (we_cnt !== 0 || err_seen !== 1'b0) begin errors++; $display("FAIL lw_we_err: got we=%0d err=%b want 0/0", we_cnt, err_seen); end
   endtask

   task automatic test_subword_loads;
      run_req(1'b0, 3'b000, 32'h43, 32'h0);
      checks++;
      if (RDATA !== 32'hFFFFFF88) begin errors++; $display("FAIL lb_43: got %h want ffffff88", RDATA); end
      run_req(1'b0, 3'b100, 32'h43, 32'h0);
      checks++;
      if (RDATA !== 32'h00000088) begin errors++; $display("FAIL lbu_43: got %h want 00000088", RDATA); end
      run_req(1'b0, 3'b001, 32'h42, 32'h0);
      checks++;
      if (RDATA !== 32'hFFFF8899) begin errors++; $display("FAIL lh_42: got %h want ffff8899", RDATA); end
      run_req(1'b0, 3'b101, 32'h40, 32'h0);
      checks++;
      if (RDATA !== 32'h0000AABB) begin errors++; $display("FAIL lhu_40: got %h want 0000aabb", RDATA); end
      run_req(1'b0, 3'b100, 32'h41, 32'h0);
      checks++;
      if (RDATA !== 32'h000000AA) begin errors++; $display("FAIL lbu_41: got %h want 000000aa", RDATA); end
   endtask

   task automatic test_subword_stores;
      preload(32'h40, 32'h8899AABB);
      run_req(1'b1, 3'b000, 32'h41, 32'h12345677);
      checks++;
      if (we_cnt !== 1 || we_cyc !== 2) begin errors++; $display("FAIL sb_we: got cnt=%0d cyc=%0d want 1/2", we_cnt, we_cyc); end
      checks++;
      if (done_cyc !== 3) begin errors++; $display("FAIL sb_latency: got %0d want 3", done_cyc); end
      checks++;
      if (mem[16] !== 32'h889977BB) begin errors++; $display("FAIL sb_mem: got %h want 889977bb", mem[16]); end
      run_req(1'b1, 3'b001, 32'h42, 32'h0000CAFE);
      checks++;
      if (mem[16] !== 32'hCAFE77BB) begin errors++; $display("FAIL sh_mem: got %h want cafe77bb", mem[16]); end
      run_req(1'b1, 3'b010, 32'h44, 32'hDEADBEEF);
      checks++;
      if (mem[17] !== 32'hDEADBEEF || done_cyc !== 2 || we_cyc !== 1) begin
         errors++; $display("FAIL sw: got mem=%h done=%0d we=%0d want deadbeef/2/1", mem[17], done_cyc, we_cyc);
      end
   endtask

   task automatic test_errors;
      logic [31:0] prev;
      preload(32'h40, 32'h8899AABB);
      prev = RDATA;
      run_req(1'b0, 3'b010, 32'h42, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      checks++;
      if (done_cyc !== 1 || err_seen !== 1'b1) begin errors++; $display("FAIL lw_mis_err: got done=%0d err=%b want 1/1", done_cyc, err_seen); end
      checks++;
      if (we_cnt !== 0 || a_cnt !== 0 || RDATA !== prev) begin
         errors++; $display("FAIL lw_mis_quiet: got we=%0d a=%0d rdata=%h want 0/0/%h", we_cnt, a_cnt, RDATA, prev);
      end
`else
      checks++;
      if (done_cyc !== 2 || err_seen !== 1'b0 || RDATA !== 32'h8899AABB) begin
         errors++; $display("FAIL lw_mis_align: got done=%0d err=%b rdata=%h want 2/0/8899aabb", done_cyc, err_seen, RDATA);
      end
      run_req(1'b0, 3'b001, 32'h41, 32'h0);
      checks++;
      if (RDATA !== 32'hFFFFAABB) begin errors++; $display("FAIL lh_mis_align: got %h want ffffaabb", RDATA); end
`endif
      prev = RDATA;
      run_req(1'b0, 3'b111, 32'h40, 32'h0);
      checks++;
      if (done_cyc !== 1 || err_seen !== 1'b1 || RDATA !== prev) begin
         errors++; $display("FAIL f3_111: got done=%0d err=%b rdata=%h want 1/1/%h", done_cyc, err_seen, RDATA, prev);
      end
      run_req(1'b1, 3'b100, 32'h40, 32'h55);
      checks++;
      if (done_cyc !== 1 || err_seen !== 1'b1 || we_cnt !== 0 || mem[16] !== 32'h8899AABB) begin
         errors++; $display("FAIL store_bu: got done=%0d err=%b we=%0d mem=%h want 1/1/0/8899aabb", done_cyc, err_seen, we_cnt, mem[16]);
      end
   endtask

   task automatic test_busy_hold;
      logic [2:0] dones;
      logic       saw_done;
      preload(32'h40, 32'h8899AABB);
      WR = 1'b1; FUNCT3 = 3'b000; ADDR = 32'h40; WDATA = 32'h11; REQ = 1'b1;
      tick();
      for (int n = 0; n < 3; n++) begin
         dones[n] = DONE;
         tick();
      end
      checks++;
      if (dones !== 3'b100) begin errors++; $display("FAIL busy_done_seq: got %b want 100", dones); end
      checks++;
      if (BUSY !== 1'b0) begin errors++; $display("FAIL busy_idle_gap: got %b want 0", BUSY); end
      tick();
      REQ = 1'b0;
      checks++;
      if (BUSY !== 1'b1) begin errors++; $display("FAIL busy_reaccept: got %b want 1", BUSY); end
      saw_done = 1'b0;
      for (int n = 0; n < 6 && !saw_done; n++) begin
         saw_done = DONE;
         tick();
      end
      checks++;
      if (saw_done !== 1'b1 || mem[16] !== 32'h8899AA11) begin
         errors++; $display("FAIL busy_second: got done=%b mem=%h want 1/8899aa11", saw_done, mem[16]);
      end
   endtask

   task automatic test_reset_abort;
      logic bad;
      preload(32'h40, 32'h8899AABB);
      WR = 1'b1; FUNCT3 = 3'b000; ADDR = 32'h41; WDATA = 32'h55; REQ = 1'b1;
      tick();
      REQ = 1'b0;
      tick();
      checks++;
      if (BUSY !== 1'b1 || MEM_WE !== 1'b1) begin errors++; $display("FAIL abort_in_write: got busy=%b we=%b want 1/1", BUSY, MEM_WE); end
      RST = 1'b1;
      #1;
      checks++;
      if (MEM_WE !== 1'b0) begin errors++; $display("FAIL abort_we_gate: got %b want 0", MEM_WE); end
      tick();
      RST = 1'b0;
      bad = 1'b0;
      for (int n = 0; n < 4; n++) begin
         if (DONE || MEM_WE || BUSY) bad = 1'b1;
         tick();
      end
      checks++;
      if (bad !== 1'b0 || mem[16] !== 32'h8899AABB) begin
         errors++; $display("FAIL abort_after: got activity=%b mem=%h want 0/8899aabb", bad, mem[16]);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      test_reset();
      test_load_word();
      test_subword_loads();
      test_subword_stores();
      test_errors();
      test_busy_hold();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end
endmodule
